shift_reg_piso_tx: RTL and testbench
====================================

# shift_reg_piso_tx

Parallel-in serial-out framed transmitter, the send side of the serial-in parallel-out shift-register link. It accepts a parallel word through a valid/ready handshake and shifts it out MSB-first, one bit per DIV clocks. Alongside the data it emits a one-cycle bit strobe that drives the receiving shift register's EN input directly, plus frame/done flags. It sits between a sample/control source (ADC path, register file) and any serial link or downstream SIPO.

## Interface
- WIDTH, 16: word length in bits, must be ≥2.
- DIV, 4: CLK cycles per serial bit, must be ≥1.
- GAP_BITS, 1: idle bit periods inserted after each frame, must be ≥0.

- CLK  input  1  clock, rising edge active.
- RST  input  1  reset, asynchronous, active-high.
- DIN  input  WIDTH  parallel word to send.
- DIN_VLD  input  1  DIN valid.
- DIN_RDY  output  1  block can accept a word; high only in IDLE.
- SOUT  output  1  serial data, MSB first; 0 when not in a frame.
- FRAME  output  1  high for every cycle in which SOUT carries a data bit.
- BIT_EN  output  1  one-cycle strobe in the last cycle of each bit period; the receiver samples SOUT when this is high.
- DONE  output  1  one-cycle pulse, coincident with the final BIT_EN of a frame.
- BUSY  output  1  high in SHIFT or GAP.

## Operation
- State machine: IDLE → SHIFT → GAP → IDLE. If GAP_BITS=0, SHIFT goes straight to IDLE.
- Registers:
  - shift_R[WIDTH-1:0]
  - divider cnt, range 0..DIV-1
  - bit index bidx, range 0..WIDTH-1
  - gap counter
- IDLE:
  - DIN_RDY=1.
  - On an edge with DIN_VLD=1, load shift_R←DIN, clear cnt and bidx, and go to SHIFT.
- SHIFT:
  - SOUT=shift_R[WIDTH-1] and FRAME=1.
  - cnt increments each cycle.
  - When cnt=DIV-1, BIT_EN=1 for that cycle.
  - On that edge: cnt←0, shift_R shifts left with 0 filled in, and bidx increments.
  - When cnt=DIV-1 and bidx=WIDTH-1, DONE=1. On that edge go to GAP, or to IDLE if GAP_BITS=0.
- GAP:
  - SOUT=0, FRAME=0, BIT_EN=0.
  - Lasts GAP_BITS×DIV cycles, then goes to IDLE.
- DIN_VLD outside IDLE is ignored. Nothing is captured, and upstream must hold DIN/DIN_VLD until DIN_RDY.
- DIN is sampled only on the accepting edge. Changes to DIN afterwards do not affect the frame in flight.
- DIV=1: BIT_EN is high on every SHIFT cycle, and the frame lasts WIDTH cycles.
- Output decode:
  - BIT_EN, DONE, FRAME, BUSY and DIN_RDY are decoded from state/counter registers only, never from inputs.
  - SOUT is shift_R MSB gated by FRAME.
- Reset, including mid-frame:
  - State←IDLE; shift_R, cnt, bidx and gap counter ←0.
  - Outputs: SOUT=0, FRAME=0, BIT_EN=0, DONE=0, BUSY=0, DIN_RDY=1.
  - No acceptance occurs while RST=1.
  - A partial frame is abandoned and never resumed.

## Timing
- Accepting edge = E0. The cycle following E0 is cycle 1.
- From cycle 1: FRAME=1, SOUT=DIN[WIDTH-1], BUSY=1, DIN_RDY=0.
- Bit i (i=0..WIDTH-1) occupies cycles i×DIV+1 to (i+1)×DIV. Its BIT_EN is in cycle (i+1)×DIV.
- DONE is in cycle WIDTH×DIV.
- FRAME drops in cycle WIDTH×DIV+1.
- DIN_RDY returns in cycle (WIDTH+GAP_BITS)×DIV+1.
- Maximum throughput is one word per (WIDTH+GAP_BITS)×DIV+1 cycles. With GAP_BITS=0 there is always one IDLE cycle between frames.
- SOUT is stable for the whole bit period, including the BIT_EN cycle. A SIPO clocked on the same CLK with EN=BIT_EN and IN=SOUT captures each bit exactly once.

## Test plan
- Basic frame (WIDTH=8, DIV=4, GAP_BITS=1), send 0xA5 at E0:
  - SOUT sequence is 1,0,1,0,0,1,0,1, each held 4 cycles.
  - BIT_EN occurs at cycles 4,8,…,32.
  - DONE occurs at cycle 32.
  - FRAME=0 in cycles 33–36; DIN_RDY=1 at cycle 37.
- Loopback (same parameters): connect to a SIPO with SHLEN=8, EN=BIT_EN, IN=SOUT, and send 0x3C, then 0xFF, then 0x01. The SIPO OUT must equal each word on the edge after its DONE.
- Back-to-back with DIN_VLD held high (DIV=1, GAP_BITS=0, WIDTH=8):
  - Words are accepted every 9 cycles.
  - Exactly one idle cycle (FRAME=0, SOUT=0) separates frames.
  - No bit is lost or duplicated.
- Busy-time stimulus (DIV=4):
  - Change DIN and pulse DIN_VLD during SHIFT. The transmitted word is unchanged and no second frame starts until IDLE.
  - Hold DIN_VLD=1 with a new DIN at IDLE. The new DIN is accepted at the first IDLE edge.
- Reset mid-frame: assert RST during bit 3.
  - Asynchronously, without waiting for an edge: SOUT=0, FRAME=0, BIT_EN=0, BUSY=0.
  - After release, DIN_RDY=1 and the next word is sent complete from its MSB.
- DIV=1 corner (WIDTH=2, DIV=1, GAP_BITS=0), send 2'b10:
  - BIT_EN is high in cycles 1 and 2, with SOUT=1 then 0.
  - DONE occurs at cycle 2; DIN_RDY returns at cycle 3.

Source files
------------

// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out framed transmitter: accepts a word on valid/ready and
// shifts it out MSB-first, one bit per DIV clocks, with a per-bit strobe for a SIPO.
module shift_reg_piso_tx #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DIV      = 4,
  parameter int unsigned GAP_BITS = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VLD,
  output logic             DIN_RDY,
  output logic             SOUT,
  output logic             FRAME,
  output logic             BIT_EN,
  output logic             DONE,
  output logic             BUSY
);

  localparam int unsigned CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIDX_W   = $clog2(WIDTH);
  localparam int unsigned GAP_LEN  = GAP_BITS * DIV;
  localparam int unsigned GAP_W    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam int unsigned GAP_LAST = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_r, state_nxt;
  logic [WIDTH-1:0]   shift_r, shift_nxt;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt;
  logic [BIDX_W-1:0]  bidx_r, bidx_nxt;
  logic [GAP_W-1:0]   gap_r, gap_nxt;

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      shift_r <= '0;
      cnt_r   <= '0;
      bidx_r  <= '0;
      gap_r   <= '0;
    end else begin
      state_r <= state_nxt;
      shift_r <= shift_nxt;
      cnt_r   <= cnt_nxt;
      bidx_r  <= bidx_nxt;
      gap_r   <= gap_nxt;
    end
  end

  // Next-state and output decode; outputs depend on registers only.
  always_comb begin
    state_nxt = state_r;
    shift_nxt = shift_r;
    cnt_nxt   = cnt_r;
    bidx_nxt  = bidx_r;
    gap_nxt   = gap_r;
    DIN_RDY   = 1'b0;
    SOUT      = 1'b0;
    FRAME     = 1'b0;
    BIT_EN    = 1'b0;
    DONE      = 1'b0;
    BUSY      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        DIN_RDY = 1'b1;
        if (DIN_VLD) begin
          shift_nxt = DIN;
          cnt_nxt   = '0;
          bidx_nxt  = '0;
          gap_nxt   = '0;
          state_nxt = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        FRAME = 1'b1;
        BUSY  = 1'b1;
        SOUT  = shift_r[WIDTH-1];
        if (cnt_r == CNT_W'(DIV - 1)) begin
          // Last cycle of the bit period: strobe, then advance to the next bit.
          BIT_EN    = 1'b1;
          cnt_nxt   = '0;
          shift_nxt = {shift_r[WIDTH-2:0], 1'b0};
          if (bidx_r == BIDX_W'(WIDTH - 1)) begin
            DONE      = 1'b1;
            bidx_nxt  = '0;
            gap_nxt   = '0;
            state_nxt = (GAP_LEN > 0) ? ST_GAP : ST_IDLE;
          end else begin
            bidx_nxt = bidx_r + BIDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt_r + CNT_W'(1);
        end
      end

      ST_GAP: begin
        BUSY = 1'b1;
        if (gap_r == GAP_W'(GAP_LAST)) begin
          gap_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          gap_nxt = gap_r + GAP_W'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Randomized self-checking bench for shift_reg_piso_tx; expected waveforms come
// from a cycle-position model of a frame, with a bit-collecting receiver.
module tb_shift_reg_piso_tx;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Instance A: WIDTH=8, DIV=4, GAP_BITS=1
  logic [7:0] a_din = '0;
  logic       a_vld = 1'b0;
  logic       a_rdy, a_sout, a_frame, a_biten, a_done, a_busy;
  // Instance B: WIDTH=8, DIV=1, GAP_BITS=0
  logic [7:0] b_din = '0;
  logic       b_vld = 1'b0;
  logic       b_rdy, b_sout, b_frame, b_biten, b_done, b_busy;
  // Instance C: WIDTH=2, DIV=1, GAP_BITS=0
  logic [1:0] c_din = '0;
  logic       c_vld = 1'b0;
  logic       c_rdy, c_sout, c_frame, c_biten, c_done, c_busy;

  shift_reg_piso_tx #(.WIDTH(8), .DIV(4), .GAP_BITS(1)) u_a (
    .CLK(CLK), .RST(RST), .DIN(a_din), .DIN_VLD(a_vld), .DIN_RDY(a_rdy),
    .SOUT(a_sout), .FRAME(a_frame), .BIT_EN(a_biten), .DONE(a_done), .BUSY(a_busy));

  shift_reg_piso_tx #(.WIDTH(8), .DIV(1), .GAP_BITS(0)) u_b (
    .CLK(CLK), .RST(RST), .DIN(b_din), .DIN_VLD(b_vld), .DIN_RDY(b_rdy),
    .SOUT(b_sout), .FRAME(b_frame), .BIT_EN(b_biten), .DONE(b_done), .BUSY(b_busy));

  shift_reg_piso_tx #(.WIDTH(2), .DIV(1), .GAP_BITS(0)) u_c (
    .CLK(CLK), .RST(RST), .DIN(c_din), .DIN_VLD(c_vld), .DIN_RDY(c_rdy),
    .SOUT(c_sout), .FRAME(c_frame), .BIT_EN(c_biten), .DONE(c_done), .BUSY(c_busy));

  // Receiving shift register on instance A: EN=BIT_EN, IN=SOUT
  logic [7:0] sipo;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          sipo <= '0;
    else if (a_biten) sipo <= {sipo[6:0], a_sout};
  end

  // Expected {SOUT,FRAME,BIT_EN,DONE,BUSY,DIN_RDY} in cycle k after the accepting edge
  function automatic logic [5:0] exp_vec(input int w, input int d, input int g,
                                         input logic [15:0] word, input int k);
    logic s;
    logic be;
    logic dn;
    if (k >= 1 && k <= w * d) begin
      s  = word[w - 1 - (k - 1) / d];
      be = ((k % d) == 0);
      dn = (k == w * d);
      return {s, 1'b1, be, dn, 1'b1, 1'b0};
    end else if (k > w * d && k <= (w + g) * d) begin
      return 6'b000010;
    end
    return 6'b000001;
  endfunction

  task automatic run_frame_a(input logic [7:0] word, input bit disturb, input bit chain,
                             input logic [7:0] next_word, input bit preloaded);
    int last;
    logic [5:0] got;
    logic [5:0] exp;
    last = (8 + 1) * 4 + 1;
    if (!preloaded) begin
      @(negedge CLK);
      checks++;
      if (a_rdy !== 1'b1) begin
        failures++;
        $display("FAIL a_start_rdy got=%b exp=1", a_rdy);
      end
      a_din = word;
      a_vld = 1'b1;
    end
    for (int k = 1; k <= last; k++) begin
      @(negedge CLK);
      got = {a_sout, a_frame, a_biten, a_done, a_busy, a_rdy};
      exp = exp_vec(8, 4, 1, {8'h00, word}, k);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL a_frame word=%h cycle=%0d got=%b exp=%b", word, k, got, exp);
      end
      if (k == 8 * 4 + 1) begin
        checks++;
        if (sipo !== word) begin
          failures++;
          $display("FAIL a_loopback got=%h exp=%h", sipo, word);
        end
      end
      if (k == 1) a_vld = 1'b0;
      if (disturb && k < last - 1) begin
        a_din = 8'($urandom);
        a_vld = 1'($urandom);
      end
      if (k == last - 1) begin
        a_vld = 1'b0;
        if (chain) begin
          a_din = next_word;
          a_vld = 1'b1;
        end
      end
      if (k == last && !chain) a_vld = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    checks++;
    if ({a_sout, a_frame, a_biten, a_done, a_busy, a_rdy} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_a got=%b exp=000001", {a_sout, a_frame, a_biten, a_done, a_busy, a_rdy});
    end
    checks++;
    if ({b_sout, b_frame, b_biten, b_done, b_busy, b_rdy, c_sout, c_frame, c_biten, c_done, c_busy, c_rdy}
        !== 12'b000001000001) begin
      failures++;
      $display("FAIL reset_bc got=%b%b exp=000001000001",
               {b_sout, b_frame, b_biten, b_done, b_busy, b_rdy},
               {c_sout, c_frame, c_biten, c_done, c_busy, c_rdy});
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({a_frame, a_busy, a_rdy} !== 3'b001) begin
      failures++;
      $display("FAIL reset_release got=%b exp=001", {a_frame, a_busy, a_rdy});
    end
  endtask

  task automatic test_basic_frame;
    run_frame_a(8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int n = 0; n < 3; n++) run_frame_a(8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_loopback;
    run_frame_a(8'h3C, 1'b0, 1'b1, 8'hFF, 1'b0);
    run_frame_a(8'hFF, 1'b0, 1'b1, 8'h01, 1'b1);
    run_frame_a(8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_busy_stimulus;
    logic [7:0] w0;
    logic [7:0] w1;
    w0 = 8'($urandom);
    w1 = ~w0;
    run_frame_a(w0, 1'b1, 1'b1, w1, 1'b0);
    run_frame_a(w1, 1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] w;
    logic [5:0] got;
    logic [5:0] exp;
    w = 8'($urandom) | 8'h80;
    @(negedge CLK);
    a_din = w;
    a_vld = 1'b1;
    for (int k = 1; k <= 3 * 4 + 2; k++) begin
      @(negedge CLK);
      got = {a_sout, a_frame, a_biten, a_done, a_busy, a_rdy};
      exp = exp_vec(8, 4, 1, {8'h00, w}, k);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL rst_pre cycle=%0d got=%b exp=%b", k, got, exp);
      end
      if (k == 1) a_vld = 1'b0;
    end
    #1 RST = 1'b1;
    #1;
    got = {a_sout, a_frame, a_biten, a_done, a_busy, a_rdy};
    checks++;
    if (got !== 6'b000001) begin
      failures++;
      $display("FAIL rst_async got=%b exp=000001", got);
    end
    a_din = 8'($urandom);
    a_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      got = {a_sout, a_frame, a_biten, a_done, a_busy, a_rdy};
      checks++;
      if (got !== 6'b000001) begin
        failures++;
        $display("FAIL rst_held cycle=%0d got=%b exp=000001", k, got);
      end
    end
    a_vld = 1'b0;
    RST = 1'b0;
    run_frame_a(8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] words[4];
    logic [7:0] rx;
    logic [5:0] got;
    logic [5:0] exp;
    bit         rxq[$];
    int f;
    int j;
    words[0] = 8'hFF;
    words[1] = 8'h00;
    words[2] = 8'($urandom);
    words[3] = 8'($urandom);
    @(negedge CLK);
    b_din = words[0];
    b_vld = 1'b1;
    for (int k = 1; k <= 9 * 4; k++) begin
      @(negedge CLK);
      f = (k - 1) / 9;
      j = (k - 1) % 9 + 1;
      got = {b_sout, b_frame, b_biten, b_done, b_busy, b_rdy};
      exp = exp_vec(8, 1, 0, {8'h00, words[f]}, j);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL b2b frame=%0d cycle=%0d got=%b exp=%b", f, j, got, exp);
      end
      if (b_biten === 1'b1) rxq.push_back(b_sout);
      if (j == 1 && f < 3) b_din = words[f + 1];
      if (j == 9 && f == 3) b_vld = 1'b0;
    end
    checks++;
    if (rxq.size() != 32) begin
      failures++;
      $display("FAIL b2b_bitcount got=%0d exp=32", rxq.size());
    end else begin
      for (int n = 0; n < 4; n++) begin
        for (int b = 0; b < 8; b++) rx[7 - b] = rxq[n * 8 + b];
        checks++;
        if (rx !== words[n]) begin
          failures++;
          $display("FAIL b2b_word n=%0d got=%h exp=%h", n, rx, words[n]);
        end
      end
    end
  endtask

  task automatic test_div1_corner;
    logic [5:0] tbl[3];
    logic [5:0] got;
    logic [5:0] exp;
    logic [1:0] w;
    tbl[0] = 6'b111010;
    tbl[1] = 6'b011110;
    tbl[2] = 6'b000001;
    @(negedge CLK);
    c_din = 2'b10;
    c_vld = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      got = {c_sout, c_frame, c_biten, c_done, c_busy, c_rdy};
      checks++;
      if (got !== tbl[k - 1]) begin
        failures++;
        $display("FAIL div1_10 cycle=%0d got=%b exp=%b", k, got, tbl[k - 1]);
      end
      if (k == 1) c_vld = 1'b0;
    end
    for (int n = 0; n < 4; n++) begin
      w = 2'(n ^ 2'($urandom));
      c_din = w;
      c_vld = 1'b1;
      for (int k = 1; k <= 3; k++) begin
        @(negedge CLK);
        got = {c_sout, c_frame, c_biten, c_done, c_busy, c_rdy};
        exp = exp_vec(2, 1, 0, {14'h0, w}, k);
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL div1_rand w=%b cycle=%0d got=%b exp=%b", w, k, got, exp);
        end
        if (k == 1) c_vld = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_loopback;
    test_busy_stimulus;
    test_reset_mid_frame;
    test_back_to_back;
    test_div1_corner;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
